fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 16-bit WISC CPU. Holds the program counter, issues requests to the instruction memory, and computes PC+2 internally as a 16-bit wrap-around increment. Presents each fetched instruction with its PC and PC+2 to decode through a valid/ready handshake. Accepts branch/jump redirects from downstream and stops permanently on HALT.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset; bit 0 must be 0.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirect  in  1  load redirect_pc as the next fetch address; flushes in-flight work.
- redirect_pc  in  16  redirect target; bit 0 forced to 0 on capture.
- halt  in  1  decode saw HALT; enter HALTED.
- imem_req  out  1  fetch request; Moore output of state.
- imem_addr  out  16  fetch address, equals pc.
- imem_ack  in  1  imem_data valid for imem_addr this cycle.
- imem_data  in  16  instruction word.
- inst_valid  out  1  inst/inst_pc/inst_pc_plus2 valid.
- inst  out  16  fetched instruction.
- inst_pc  out  16  address of inst.
- inst_pc_plus2  out  16  inst_pc + 2 mod 2^16, to the branch/link logic.
- inst_ready  in  1  decode accepts this cycle.
- halted  out  1  fetch stopped.

## Operation
- States: IDLE, FETCH, HOLD, HALTED. Reset state is IDLE.
- IDLE: imem_req=0. Goes to FETCH on the next edge unconditionally.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack:
  - capture inst=imem_data, inst_pc=pc, inst_pc_plus2=pc+2.
  - pc <= pc+2.
  - go to HOLD.
- Memory is level-request: an ack refers only to the address presented in that cycle, and there are no outstanding transactions.
- HOLD: inst_valid=1. Outputs are stable until inst_valid&&inst_ready. On the handshake, go to FETCH (build without FETCH_BUFFER_EN).
- Priority, highest first: halt, redirect, normal flow.
- halt (any non-HALTED state): next state HALTED. imem_req=0, inst_valid=0, halted=1. Exit only via rst_n.
- redirect (IDLE/FETCH/HOLD):
  - pc <= {redirect_pc[15:1],1'b0}.
  - inst_valid cleared and any buffered word discarded.
  - next state FETCH.
  - an imem_ack in the same cycle is ignored.
  - a held instruction is not counted as handed over, even if inst_ready is 1.
- PC arithmetic is 16-bit unsigned. 16'hFFFE+2 wraps to 16'h0000 with no flag.

## Timing
- Reset values (asynchronous): pc=RESET_PC, state IDLE, imem_req=0, inst_valid=0, inst=0, inst_pc=0, inst_pc_plus2=0, halted=0.
- First request is the first cycle after the first clock edge following rst_n release.
- Ack in cycle N gives inst_valid=1 in cycle N+1.
- Handshake in cycle M (no buffer): imem_req=1 in M+1 at the new pc. Peak throughput is one instruction per 2 cycles.
- redirect in cycle R: imem_addr=target in R+1, and inst_valid=0 in R+1.
- halt in cycle H: halted=1 and imem_req=0 from H+1.
- rst_n asserted mid-fetch clears everything immediately. Any pending ack is lost.

## Configuration
- FETCH_BUFFER_EN defined:
  - In HOLD, imem_req stays 1 at pc, unless the skid buffer is full.
  - Ack together with a handshake loads the output registers directly and stays in HOLD. With single-cycle memory this gives back-to-back 1 instruction/cycle.
  - Ack without a handshake writes a one-entry skid buffer, and imem_req drops.
  - The next handshake moves the buffer to the outputs in the following cycle.
  - redirect and halt flush the buffer.
- Not defined: no buffer. Behaviour is exactly the FETCH/HOLD alternation above.

## Test plan
- Reset with RESET_PC=16'h0000, memory acking every cycle, inst_ready=1 → inst_pc sequence 0000,0002,0004. inst_pc_plus2 is always inst_pc+2. One instruction per 2 cycles without the buffer, per cycle with FETCH_BUFFER_EN.
- pc=16'hFFFE fetched and accepted → inst_pc_plus2=16'h0000, next imem_addr=16'h0000.
- Ack delayed 3 cycles, inst_ready held low for 4 cycles → imem_addr stable during the wait. inst/inst_pc stay stable while stalled, with exactly one handover.
- redirect with redirect_pc=16'h1235 while in HOLD with inst_ready=1 → held instruction dropped, next imem_addr=16'h1234, next inst_pc=16'h1234.
- halt and redirect asserted in the same cycle → halted=1, imem_req=0 and inst_valid=0 from the next cycle. State remains HALTED for 20 cycles of redirect/ack stimulus.
- rst_n pulsed low mid-wait → all outputs return to reset values asynchronously. Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the 16-bit WISC CPU: PC, level-request imem port, valid/ready to decode.
// Optional one-entry skid buffer for back-to-back fetch is enabled by defining FETCH_BUFFER_EN.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic [15:0] inst_pc_plus2,
  input  logic        inst_ready,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_t;

  localparam logic [15:0] RESET_PC_EVEN = RESET_PC & 16'hFFFE;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt, pc_plus2;
  logic        ack, hs, load_imem;

`ifdef FETCH_BUFFER_EN
  logic        buf_vld, buf_wr, buf_clr, load_buf;
  logic [15:0] buf_inst, buf_pc;
`endif

  assign pc_plus2   = pc + 16'd2;
  assign imem_addr  = pc;
  assign inst_valid = (state == HOLD);
  assign halted     = (state == HALTED);
`ifdef FETCH_BUFFER_EN
  assign imem_req   = (state == FETCH) || ((state == HOLD) && !buf_vld);
`else
  assign imem_req   = (state == FETCH);
`endif
  assign ack = imem_req && imem_ack;
  assign hs  = inst_valid && inst_ready;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load_imem = 1'b0;
`ifdef FETCH_BUFFER_EN
    load_buf  = 1'b0;
    buf_wr    = 1'b0;
    buf_clr   = 1'b0;
`endif
    if (state != HALTED && halt) begin
      state_nxt = HALTED;
`ifdef FETCH_BUFFER_EN
      buf_clr   = 1'b1;
`endif
    end else if (state != HALTED && redirect) begin
      // Redirect wins over any same-cycle ack or handshake.
      pc_nxt    = redirect_pc & 16'hFFFE;
      state_nxt = FETCH;
`ifdef FETCH_BUFFER_EN
      buf_clr   = 1'b1;
`endif
    end else begin
      case (state)
        IDLE:  state_nxt = FETCH;
        FETCH: begin
          if (ack) begin
            load_imem = 1'b1;
            pc_nxt    = pc_plus2;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
`ifdef FETCH_BUFFER_EN
          if (buf_vld) begin
            if (hs) begin
              load_buf = 1'b1;
              buf_clr  = 1'b1;
            end
          end else if (ack) begin
            pc_nxt = pc_plus2;
            if (hs) load_imem = 1'b1;
            else    buf_wr    = 1'b1;
          end else if (hs) begin
            state_nxt = FETCH;
          end
`else
          if (hs) state_nxt = FETCH;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC_EVEN;
      inst          <= 16'h0000;
      inst_pc       <= 16'h0000;
      inst_pc_plus2 <= 16'h0000;
`ifdef FETCH_BUFFER_EN
      buf_vld       <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (load_imem) begin
        inst          <= imem_data;
        inst_pc       <= pc;
        inst_pc_plus2 <= pc_plus2;
      end
`ifdef FETCH_BUFFER_EN
      else if (load_buf) begin
        inst          <= buf_inst;
        inst_pc       <= buf_pc;
        inst_pc_plus2 <= buf_pc + 16'd2;
      end
      if (buf_clr)     buf_vld <= 1'b0;
      else if (buf_wr) buf_vld <= 1'b1;
`endif
    end
  end

`ifdef FETCH_BUFFER_EN
  // Skid buffer payload carries no reset; buf_vld qualifies it.
  always_ff @(posedge clk) begin
    if (buf_wr) begin
      buf_inst <= imem_data;
      buf_pc   <= pc;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (default build): per-cycle model compare plus literal checkpoints.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [15:0] inst_pc_plus2;
  logic        inst_ready;
  logic        halted;

  int n_cmp = 0;
  int n_bad = 0;
  int n_hs  = 0;
  int snap;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  assign imem_data = mem(imem_addr);

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_pc_plus2(inst_pc_plus2), .inst_ready(inst_ready), .halted(halted)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: tracks whether fetch has started, whether an instruction is held, and halt.
  logic        m_live, m_have, m_halted;
  logic [15:0] m_pc, m_inst, m_ipc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_live = 1'b0; m_have = 1'b0; m_halted = 1'b0;
      m_pc = 16'h0000; m_inst = 16'h0000; m_ipc = 16'h0000;
    end else if (m_halted) begin
      m_have = 1'b0;
    end else if (halt) begin
      m_halted = 1'b1; m_have = 1'b0;
    end else if (redirect) begin
      m_pc = {redirect_pc[15:1], 1'b0}; m_have = 1'b0; m_live = 1'b1;
    end else if (!m_live) begin
      m_live = 1'b1;
    end else if (m_have) begin
      if (inst_ready) m_have = 1'b0;
    end else if (imem_ack) begin
      m_inst = mem(m_pc); m_ipc = m_pc; m_have = 1'b1; m_pc = m_pc + 16'd2;
    end
  end

  // Handover counter (decode actually took an instruction).
  always @(posedge clk) begin
    if (rst_n && inst_valid && inst_ready && !halt && !redirect) n_hs++;
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic req_exp;
    req_exp = m_live && !m_have && !m_halted;
    chk1("m_req", imem_req, req_exp);
    chk1("m_valid", inst_valid, m_have);
    chk1("m_halted", halted, m_halted);
    if (req_exp) chk("m_addr", imem_addr, m_pc);
    if (m_have) begin
      chk("m_inst", inst, m_inst);
      chk("m_inst_pc", inst_pc, m_ipc);
      chk("m_pc_plus2", inst_pc_plus2, m_ipc + 16'd2);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk1({nm, "_req"}, imem_req, 1'b0);
    chk1({nm, "_valid"}, inst_valid, 1'b0);
    chk1({nm, "_halted"}, halted, 1'b0);
    chk({nm, "_inst"}, inst, 16'h0000);
    chk({nm, "_inst_pc"}, inst_pc, 16'h0000);
    chk({nm, "_plus2"}, inst_pc_plus2, 16'h0000);
    chk({nm, "_addr"}, imem_addr, 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
    imem_ack = 1'b1; inst_ready = 1'b1;
    #2;
    chk_reset("rst0");
    step(1);
    rst_n = 1'b1;

    // Sequential fetch: one instruction per two cycles.
    step(2);
    chk1("seq0_valid", inst_valid, 1'b1);
    chk("seq0_pc", inst_pc, 16'h0000);
    chk("seq0_plus2", inst_pc_plus2, 16'h0002);
    chk("seq0_inst", inst, 16'hC3A5);
    step(2);
    chk("seq1_pc", inst_pc, 16'h0002);
    step(2);
    chk("seq2_pc", inst_pc, 16'h0004);
    step(1);
    chk1("seq_gap_valid", inst_valid, 1'b0);
    chk("seq_next_addr", imem_addr, 16'h0006);

    // Wrap at FFFE.
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step(1);
    redirect = 1'b0;
    chk("wrap_addr", imem_addr, 16'hFFFE);
    chk1("wrap_req", imem_req, 1'b1);
    step(1);
    chk("wrap_inst_pc", inst_pc, 16'hFFFE);
    chk("wrap_plus2", inst_pc_plus2, 16'h0000);
    step(1);
    chk("wrap_next_addr", imem_addr, 16'h0000);

    // Delayed ack and stalled decode.
    imem_ack = 1'b0; inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("wait_addr", imem_addr, 16'h0000);
      chk1("wait_req", imem_req, 1'b1);
    end
    imem_ack = 1'b1;
    step(1);
    imem_ack = 1'b0;
    chk("stall_first_pc", inst_pc, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk1("stall_valid", inst_valid, 1'b1);
      chk("stall_pc", inst_pc, 16'h0000);
      chk("stall_inst", inst, 16'hC3A5);
    end
    snap = n_hs;
    inst_ready = 1'b1;
    step(1);
    chk("stall_handovers", 16'(n_hs - snap), 16'd1);
    chk1("stall_after_valid", inst_valid, 1'b0);
    chk("stall_after_addr", imem_addr, 16'h0002);

    // Redirect while holding with ready high drops the held word.
    imem_ack = 1'b1;
    step(1);
    chk("redir_held_pc", inst_pc, 16'h0002);
    redirect = 1'b1; redirect_pc = 16'h1235;
    snap = n_hs;
    step(1);
    redirect = 1'b0;
    chk1("redir_valid", inst_valid, 1'b0);
    chk("redir_addr", imem_addr, 16'h1234);
    chk("redir_handovers", 16'(n_hs - snap), 16'd0);
    step(1);
    chk("redir_inst_pc", inst_pc, 16'h1234);
    chk("redir_inst", inst, mem(16'h1234));

    // Halt beats redirect, then stays halted.
    halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h4000;
    step(1);
    halt = 1'b0; redirect = 1'b0;
    chk1("halt_halted", halted, 1'b1);
    chk1("halt_req", imem_req, 1'b0);
    chk1("halt_valid", inst_valid, 1'b0);
    for (int i = 0; i < 20; i++) begin
      redirect    = 1'($urandom_range(0, 1));
      redirect_pc = 16'($urandom_range(0, 65535));
      imem_ack    = 1'($urandom_range(0, 1));
      inst_ready  = 1'($urandom_range(0, 1));
      step(1);
      chk1("halted_stay", halted, 1'b1);
      chk1("halted_req", imem_req, 1'b0);
      chk1("halted_valid", inst_valid, 1'b0);
    end

    // Asynchronous reset out of HALTED, then mid-wait.
    redirect = 1'b0; imem_ack = 1'b1; inst_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_halt");
    step(1);
    rst_n = 1'b1; imem_ack = 1'b0;
    step(1);
    chk("restart_addr", imem_addr, 16'h0000);
    redirect = 1'b1; redirect_pc = 16'h0AB0;
    step(1);
    redirect = 1'b0;
    step(2);
    chk("midwait_addr", imem_addr, 16'h0AB0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    step(1);
    rst_n = 1'b1; imem_ack = 1'b1;
    step(1);
    chk1("rst_restart_req", imem_req, 1'b1);
    chk("rst_restart_addr", imem_addr, 16'h0000);
    step(1);
    chk1("rst_restart_valid", inst_valid, 1'b1);
    chk("rst_restart_pc", inst_pc, 16'h0000);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
